istate_bank: RTL and testbench

- Parametrised internal-state register bank: NUM_REGS x DATA_W registers plus a PL_W-bit privilege-level (pl) register.
- Adds a shadow bank with a multi-cycle save/restore sequencer for trap entry and return.
- Sits beside the core register file; read by decode/execute, written by execute/writeback and by trap control.
- Entry 0 is hardwired zero.

---
 rtl/istate_bank_if.sv | 30 +++
 rtl/istate_bank.sv | 84 ++++++++
 tb/tb_istate_bank.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/istate_bank_if.sv
// istate_bank_if: access, privilege-level and save/restore signals of the internal-state bank
interface istate_bank_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int PL_W   = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_out;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd2_out;
    logic              wr_pl_en;
    logic [PL_W-1:0]   wr_pl_data;
    logic [PL_W-1:0]   rd_pl_out;
    logic              save_req;
    logic              restore_req;
    logic              busy;
    logic              done;
    logic              wr_err;
    modport master (
        output wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, wr_pl_en, wr_pl_data, save_req, restore_req,
        input  rd1_out, rd2_out, rd_pl_out, busy, done, wr_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, wr_pl_en, wr_pl_data, save_req, restore_req,
        output rd1_out, rd2_out, rd_pl_out, busy, done, wr_err
    );
endinterface

// File: rtl/istate_bank.sv
// istate_bank: internal-state register bank with shadow save/restore sequencer; ISTATE_BYPASS_EN adds same-cycle write-to-read bypass
module istate_bank #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 6,
    parameter int PL_W     = 4
) (
    input logic          clk,
    input logic          rst,
    istate_bank_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FIN} state_t;
    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] live [NUM_REGS];
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [PL_W-1:0]   pl, pl_sh;
    logic [DATA_W-1:0] rd1_q, rd2_q;
    logic              idle, wr_ok, pl_ok, start_save, start_rest, last, wr_err_q;

    function automatic logic in_range(logic [ADDR_W-1:0] a);
        return a != '0 && 32'(a) < NUM_REGS;
    endfunction

    assign idle       = state == IDLE;
    assign wr_ok      = bus.wr_en && idle && in_range(bus.wr_addr);
    assign pl_ok      = bus.wr_pl_en && idle;
    assign start_save = idle && bus.save_req;
    assign start_rest = idle && bus.restore_req && !bus.save_req;
    assign last       = idx == IDX_W'(NUM_REGS - 1);
    assign rd1_q      = in_range(bus.rd1_addr) ? live[bus.rd1_addr[IDX_W-1:0]] : '0;
    assign rd2_q      = in_range(bus.rd2_addr) ? live[bus.rd2_addr[IDX_W-1:0]] : '0;
    assign bus.wr_err = wr_err_q;
`ifdef ISTATE_BYPASS_EN
    assign bus.rd1_out   = wr_ok && bus.rd1_addr == bus.wr_addr ? bus.wr_data : rd1_q;
    assign bus.rd2_out   = wr_ok && bus.rd2_addr == bus.wr_addr ? bus.wr_data : rd2_q;
    assign bus.rd_pl_out = pl_ok ? bus.wr_pl_data : pl;
`else
    assign bus.rd1_out   = rd1_q;
    assign bus.rd2_out   = rd2_q;
    assign bus.rd_pl_out = pl;
`endif

    // sequencer state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // sequencer next state and status outputs; save wins over restore
    always_comb begin
        state_nxt = state;
        bus.busy  = !idle;
        bus.done  = state == FIN;
        case (state)
            IDLE:          state_nxt = start_save ? SAVE : start_rest ? RESTORE : IDLE;
            SAVE, RESTORE: state_nxt = last ? FIN : state;
            default:       state_nxt = IDLE;
        endcase
    end

    // live/shadow/pl storage, one entry copied per sequencer cycle, dropped-write flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            pl       <= '0;
            pl_sh    <= '0;
            idx      <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en && !wr_ok;
            if (wr_ok) live[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
            if (start_save) pl_sh <= pl;
            pl <= start_rest ? pl_sh : pl_ok ? bus.wr_pl_data : pl;
            if (start_save || start_rest) idx <= IDX_W'(1);
            else if (!last && (state == SAVE || state == RESTORE)) idx <= idx + IDX_W'(1);
            if (state == SAVE) shadow[idx] <= live[idx];
            if (state == RESTORE) live[idx] <= shadow[idx];
        end
    end
endmodule

// File: tb/tb_istate_bank.sv
// tb_istate_bank: vector table, directed save/restore/reset sequences and random run against a behavioural model
module tb_istate_bank;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;

    istate_bank_if #(.DATA_W(64), .ADDR_W(6), .PL_W(4)) bus ();
    istate_bank #(.DATA_W(64), .NUM_REGS(N), .ADDR_W(6), .PL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] m_live [N];
    logic [63:0] m_sh [N];
    logic [3:0]  m_pl, m_shpl;
    bit          m_err, kind_save;
    int          age;

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic [5:0]  r1, r2;
        logic [63:0] e1, e2;
        logic        ee;
    } vec_t;
    vec_t vt [7];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic bit ok(logic [5:0] a);
        return a != 0 && int'(a) < N;
    endfunction

    function automatic logic [63:0] exp_rd(logic [5:0] a);
        if (!ok(a)) return 64'd0;
`ifdef ISTATE_BYPASS_EN
        if (age == 0 && bus.wr_en && ok(bus.wr_addr) && bus.wr_addr == a) return bus.wr_data;
`endif
        return m_live[a[2:0]];
    endfunction

    function automatic logic [3:0] exp_pl();
`ifdef ISTATE_BYPASS_EN
        if (age == 0 && bus.wr_pl_en) return bus.wr_pl_data;
`endif
        return m_pl;
    endfunction

    task automatic check_model();
        chk("model_rd1", bus.rd1_out, exp_rd(bus.rd1_addr));
        chk("model_rd2", bus.rd2_out, exp_rd(bus.rd2_addr));
        chk("model_pl", 64'(bus.rd_pl_out), 64'(exp_pl()));
        chk("model_busy", 64'(bus.busy), 64'(age != 0));
        chk("model_done", 64'(bus.done), 64'(age == N));
        chk("model_wr_err", 64'(bus.wr_err), 64'(m_err));
    endtask

    task automatic model_step();
        logic [3:0] old_pl;
        bit idl;
        old_pl = m_pl;
        idl = age == 0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_live[i] = 0;
                m_sh[i] = 0;
            end
            m_pl = 0;
            m_shpl = 0;
            m_err = 0;
            age = 0;
        end else begin
            m_err = bus.wr_en && !(idl && ok(bus.wr_addr));
            if (idl && bus.wr_en && ok(bus.wr_addr)) m_live[bus.wr_addr[2:0]] = bus.wr_data;
            if (idl && bus.wr_pl_en) m_pl = bus.wr_pl_data;
            if (age >= 1 && age < N) begin
                if (kind_save) m_sh[age] = m_live[age];
                else m_live[age] = m_sh[age];
            end
            if (idl && bus.save_req) begin
                m_shpl = old_pl;
                kind_save = 1;
                age = 1;
            end else if (idl && bus.restore_req) begin
                m_pl = m_shpl;
                kind_save = 0;
                age = 1;
            end else if (age == N) age = 0;
            else if (age > 0) age++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.wr_en = 0;
        bus.wr_pl_en = 0;
        bus.save_req = 0;
        bus.restore_req = 0;
    endtask

    task automatic write(int a, logic [63:0] d);
        bus.wr_en = 1;
        bus.wr_addr = 6'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic run_seq(bit s, bit r, output int n);
        bus.save_req = s;
        bus.restore_req = r;
        #1 check_model();
        tick();
        clear_in();
        n = 1;
        while (!bus.done && n < 40) begin
            check_model();
            tick();
            n++;
        end
        check_model();
        tick();
    endtask

    function automatic logic [5:0] pick();
        int r = $urandom_range(0, 9);
        return r == 9 ? 6'd63 : 6'(r);
    endfunction

    initial begin
        int n;
        vt[0] = '{1'b1, 6'd3, 64'hDEAD_BEEF, 6'd3, 6'd0, 64'hDEAD_BEEF, 64'd0, 1'b0};
        vt[1] = '{1'b1, 6'd0, 64'h1234, 6'd0, 6'd3, 64'd0, 64'hDEAD_BEEF, 1'b1};
        vt[2] = '{1'b0, 6'd0, 64'h0, 6'd0, 6'd3, 64'd0, 64'hDEAD_BEEF, 1'b0};
        vt[3] = '{1'b1, 6'd8, 64'hAAAA, 6'd8, 6'd63, 64'd0, 64'd0, 1'b1};
        vt[4] = '{1'b1, 6'd7, 64'h77, 6'd7, 6'd3, 64'h77, 64'hDEAD_BEEF, 1'b0};
        vt[5] = '{1'b0, 6'd5, 64'hFF, 6'd5, 6'd8, 64'd0, 64'd0, 1'b0};
        vt[6] = '{1'b1, 6'd63, 64'h1, 6'd63, 6'd7, 64'd0, 64'h77, 1'b1};
        clear_in();
        bus.wr_addr = 0;
        bus.wr_data = 0;
        bus.rd1_addr = 3;
        bus.rd2_addr = 7;
        bus.wr_pl_data = 0;
        rst = 1;
        age = 0;
        tick();
        tick();
        rst = 0;
        #1;
        chk("reset_rd1", bus.rd1_out, 64'd0);
        chk("reset_rd2", bus.rd2_out, 64'd0);
        chk("reset_pl", 64'(bus.rd_pl_out), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_wr_err", 64'(bus.wr_err), 64'd0);

        for (int i = 0; i < 7; i++) begin
            bus.wr_en = vt[i].we;
            bus.wr_addr = vt[i].wa;
            bus.wr_data = vt[i].wd;
            bus.rd1_addr = vt[i].r1;
            bus.rd2_addr = vt[i].r2;
            #1 check_model();
            tick();
            bus.wr_en = 0;
            #1;
            chk($sformatf("vec%0d_rd1", i), bus.rd1_out, vt[i].e1);
            chk($sformatf("vec%0d_rd2", i), bus.rd2_out, vt[i].e2);
            chk($sformatf("vec%0d_wr_err", i), 64'(bus.wr_err), 64'(vt[i].ee));
        end

        bus.wr_pl_en = 1;
        bus.wr_pl_data = 2;
        for (int i = 1; i < N; i++) begin
            write(i, 64'(i * 17));
            bus.wr_pl_en = 0;
        end
        run_seq(1, 0, n);
        chk("save_latency", 64'(n), 64'(N));
        chk("save_busy_after", 64'(bus.busy), 64'd0);
        bus.wr_pl_en = 1;
        bus.wr_pl_data = 0;
        for (int i = 1; i < N; i++) begin
            write(i, 64'd0);
            bus.wr_pl_en = 0;
        end
        bus.rd1_addr = 5;
        #1 chk("cleared_reg5", bus.rd1_out, 64'd0);
        chk("cleared_pl", 64'(bus.rd_pl_out), 64'd0);
        run_seq(0, 1, n);
        chk("restore_latency", 64'(n), 64'(N));
        chk("restore_busy_after", 64'(bus.busy), 64'd0);
        for (int i = 1; i < N; i++) begin
            bus.rd1_addr = 6'(i);
            #1 chk($sformatf("restored_reg%0d", i), bus.rd1_out, 64'(i * 17));
        end
        chk("restored_pl", 64'(bus.rd_pl_out), 64'd2);

        bus.save_req = 1;
        #1 check_model();
        tick();
        clear_in();
        bus.wr_en = 1;
        bus.wr_addr = 2;
        bus.wr_data = 64'h99;
        bus.wr_pl_en = 1;
        bus.wr_pl_data = 5;
        #1 check_model();
        tick();
        clear_in();
        #1 chk("busy_drop_wr_err", 64'(bus.wr_err), 64'd1);
        check_model();
        tick();
        chk("busy_drop_err_once", 64'(bus.wr_err), 64'd0);
        n = 3;
        while (!bus.done && n < 40) begin
            check_model();
            tick();
            n++;
        end
        chk("busy_save_latency", 64'(n), 64'(N));
        tick();
        bus.rd1_addr = 2;
        #1 chk("busy_drop_reg2", bus.rd1_out, 64'h22);
        chk("busy_drop_pl", 64'(bus.rd_pl_out), 64'd2);

        write(1, 64'hAB);
        run_seq(1, 1, n);
        bus.rd1_addr = 1;
        #1 chk("both_req_save_wins", bus.rd1_out, 64'hAB);
        write(1, 64'd0);
        run_seq(0, 1, n);
        bus.rd1_addr = 1;
        bus.rd2_addr = 2;
        #1 chk("both_req_shadow_reg1", bus.rd1_out, 64'hAB);
        chk("both_req_shadow_reg2", bus.rd2_out, 64'h22);

        bus.restore_req = 1;
        #1 check_model();
        tick();
        clear_in();
        tick();
        tick();
        rst = 1;
        #1 chk("abort_no_done", 64'(bus.done), 64'd0);
        check_model();
        tick();
        rst = 0;
        #1 chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        for (int i = 0; i < N; i++) begin
            bus.rd1_addr = 6'(i);
            #1 chk($sformatf("abort_reg%0d", i), bus.rd1_out, 64'd0);
        end
        chk("abort_pl", 64'(bus.rd_pl_out), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check_model();
            tick();
        end
        bus.wr_pl_en = 1;
        bus.wr_pl_data = 7;
        write(3, 64'h33);
        clear_in();
        run_seq(0, 1, n);
        bus.rd1_addr = 3;
        #1 chk("abort_shadow_reg3", bus.rd1_out, 64'd0);
        chk("abort_shadow_pl", 64'(bus.rd_pl_out), 64'd0);

        write(4, 64'h44);
        bus.rd1_addr = 4;
        bus.wr_en = 1;
        bus.wr_addr = 4;
        bus.wr_data = 64'h5;
        #1;
`ifdef ISTATE_BYPASS_EN
        chk("bypass_same_cycle", bus.rd1_out, 64'h5);
`else
        chk("bypass_same_cycle", bus.rd1_out, 64'h44);
`endif
        tick();
        bus.wr_en = 0;
        #1 chk("bypass_next_cycle", bus.rd1_out, 64'h5);

        for (int c = 0; c < 600; c++) begin
            rst = $urandom_range(0, 199) == 0;
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.wr_addr = pick();
            bus.wr_data = {$urandom, $urandom};
            bus.rd1_addr = pick();
            bus.rd2_addr = pick();
            bus.wr_pl_en = $urandom_range(0, 3) == 0;
            bus.wr_pl_data = 4'($urandom_range(0, 15));
            bus.save_req = $urandom_range(0, 15) == 0;
            bus.restore_req = !bus.wr_pl_en && $urandom_range(0, 15) == 0;
            #1 check_model();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
